// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } fetch_state_t;

    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats a normal load.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_hold,
    input  logic        i_bubble,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc4,
    input  logic [31:0] i_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic [31:0] o_inst,
    output logic        o_valid
);

    logic [31:0] pc_q;
    logic [31:0] pc4_q;
    logic [31:0] inst_q;
    logic        valid_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q    <= '0;
            pc4_q   <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (i_bubble) begin
            pc_q    <= '0;
            pc4_q   <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (!i_hold) begin
            pc_q    <= i_pc;
            pc4_q   <= i_pc4;
            inst_q  <= i_inst;
            valid_q <= 1'b1;
        end
    end

    assign o_pc    = pc_q;
    assign o_pc4   = pc4_q;
    assign o_inst  = inst_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, next-PC selection, fetch FSM and IF/ID register.
// Optional FETCH_MISALIGN_CHECK_EN adds o_misalign and refuses misaligned redirects.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 2048
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic [31:0] o_addr_inst,
    input  logic [31:0] i_inst,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_pc4,
    output logic [31:0] o_if_inst,
    output logic        o_if_valid,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        o_misalign,
`endif
    output logic        o_halted
);

    // 34 bits so that a 2^30-word memory (limit 2^32) still compares correctly
    localparam logic [33:0] IMEM_LIMIT = {IMEM_WORDS[31:0], 2'b00};

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pcPlus4;
    logic [31:0]  redirTarget;
    logic         outOfRange;
    logic         misalignReq;
    logic         ifHold;
    logic         ifBubble;

    assign pcPlus4     = pc_q + 32'd4;
    assign redirTarget = alignWord(i_redirect_pc);
    assign outOfRange  = ({2'b00, pc_q} >= IMEM_LIMIT);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    assign misalignReq = |i_redirect_pc[1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= i_redirect && misalignReq && (state_q != S_BOOT);
        end
    end

    assign o_misalign = misalign_q;
`else
    logic unusedAlignBits;

    assign unusedAlignBits = |i_redirect_pc[1:0];
    assign misalignReq     = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ifHold   = 1'b0;
        ifBubble = 1'b0;
        case (state_q)
            S_BOOT: begin
                ifBubble = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (i_redirect) begin
                    ifBubble = 1'b1;
                    if (misalignReq) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d = redirTarget;
                    end
                end else if (i_halt || outOfRange) begin
                    ifBubble = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    ifBubble = i_flush;
                    if (i_stall) begin
                        ifHold = 1'b1;
                    end else begin
                        pc_d = pcPlus4;
                    end
                end
            end
            S_HALT: begin
                ifBubble = 1'b1;
                if (i_redirect && !misalignReq) begin
                    pc_d    = redirTarget;
                    state_d = S_RUN;
                end
            end
            default: begin
                ifBubble = 1'b1;
                state_d  = S_BOOT;
            end
        endcase
    end

    if_id_reg u_if_id (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_hold   (ifHold),
        .i_bubble (ifBubble),
        .i_pc     (pc_q),
        .i_pc4    (pcPlus4),
        .i_inst   (i_inst),
        .o_pc     (o_if_pc),
        .o_pc4    (o_if_pc4),
        .o_inst   (o_if_inst),
        .o_valid  (o_if_valid)
    );

    assign o_addr_inst = pc_q;
    assign o_halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a vector table for the main sequence plus
// hand-written wrap-around and asynchronous-reset sequences.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        string       name;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic        halt;
        logic [31:0] eAddr;
        logic [31:0] ePc;
        logic        eValid;
        logic        eHalted;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, redirect, halt;
    logic [31:0] redirectPc;

    logic [31:0] addrMain, instMain, ifPcMain, ifPc4Main, ifInstMain;
    logic        validMain, haltedMain;
    logic [31:0] addrWide, instWide, ifPcWide, ifPc4Wide, ifInstWide;
    logic        validWide, haltedWide;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misMain, misWide;
`endif

    int checks = 0;
    int passes = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    // Instruction memory model: a distinct, address-derived word per location
    function automatic logic [31:0] instOf(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    assign instMain = instOf(addrMain);
    assign instWide = instOf(addrWide);

    inst_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(2048)) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_redirect    (redirect),
        .i_redirect_pc (redirectPc),
        .i_halt        (halt),
        .o_addr_inst   (addrMain),
        .i_inst        (instMain),
        .o_if_pc       (ifPcMain),
        .o_if_pc4      (ifPc4Main),
        .o_if_inst     (ifInstMain),
        .o_if_valid    (validMain),
`ifdef FETCH_MISALIGN_CHECK_EN
        .o_misalign    (misMain),
`endif
        .o_halted      (haltedMain)
    );

    inst_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(32'h4000_0000)) u_wide (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_redirect    (redirect),
        .i_redirect_pc (redirectPc),
        .i_halt        (halt),
        .o_addr_inst   (addrWide),
        .i_inst        (instWide),
        .o_if_pc       (ifPcWide),
        .o_if_pc4      (ifPc4Wide),
        .o_if_inst     (ifInstWide),
        .o_if_valid    (validWide),
`ifdef FETCH_MISALIGN_CHECK_EN
        .o_misalign    (misWide),
`endif
        .o_halted      (haltedWide)
    );

    task automatic addV(input string n, input logic st, input logic fl, input logic rd,
                        input logic [31:0] rp, input logic ht, input logic [31:0] ea,
                        input logic [31:0] ep, input logic ev, input logic eh);
        vec_t v;
        v.name = n; v.stall = st; v.flush = fl; v.redir = rd; v.rpc = rp; v.halt = ht;
        v.eAddr = ea; v.ePc = ep; v.eValid = ev; v.eHalted = eh;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic st, input logic fl, input logic rd,
                                 input logic [31:0] rp, input logic ht);
        stall = st; flush = fl; redirect = rd; redirectPc = rp; halt = ht;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string n, input logic [31:0] eAddr,
                               input logic [31:0] ePc, input logic eValid, input logic eHalted);
        logic [31:0] eInst;
        logic        ok;
        eInst = eValid ? instOf(ePc) : NOP;
        ok = (addrMain === eAddr) && (validMain === eValid) &&
             (ifInstMain === eInst) && (haltedMain === eHalted);
        if (eValid) ok = ok && (ifPcMain === ePc) && (ifPc4Main === ePc + 32'd4);
        checks++;
        if (ok) passes++;
        else $display("[TB] FAIL %s: got addr=%h valid=%b inst=%h pc=%h pc4=%h halted=%b; want addr=%h valid=%b inst=%h pc=%h pc4=%h halted=%b",
                      n, addrMain, validMain, ifInstMain, ifPcMain, ifPc4Main, haltedMain,
                      eAddr, eValid, eInst, ePc, ePc + 32'd4, eHalted);
    endtask

    task automatic checkReset(input string n);
        logic ok;
        ok = (addrMain === 32'h0) && (ifPcMain === 32'h0) && (ifPc4Main === 32'h0) &&
             (ifInstMain === NOP) && (validMain === 1'b0) && (haltedMain === 1'b0) &&
             (addrWide === 32'h0) && (validWide === 1'b0) && (haltedWide === 1'b0);
        checks++;
        if (ok) passes++;
        else $display("[TB] FAIL %s: got addr=%h pc=%h pc4=%h inst=%h valid=%b halted=%b wideAddr=%h; want zeros, inst=%h",
                      n, addrMain, ifPcMain, ifPc4Main, ifInstMain, validMain, haltedMain, addrWide, NOP);
    endtask

    task automatic checkBit(input string n, input logic got, input logic want);
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s: got %b want %b", n, got, want);
    endtask

    task automatic checkWord(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s: got %h want %h", n, got, want);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 0; flush = 0; redirect = 0; redirectPc = '0; halt = 0;

        //    name          st fl rd rpc           ht  addr          ifPc          v  h
        addV("boot",        0, 0, 0, 32'h0,        0,  32'h0,        32'h0,        0, 0);
        addV("run0",        0, 0, 0, 32'h0,        0,  32'h4,        32'h0,        1, 0);
        addV("run4",        0, 0, 0, 32'h0,        0,  32'h8,        32'h4,        1, 0);
        addV("stall1",      1, 0, 0, 32'h0,        0,  32'h8,        32'h4,        1, 0);
        addV("stall2",      1, 0, 0, 32'h0,        0,  32'h8,        32'h4,        1, 0);
        addV("unstall",     0, 0, 0, 32'h0,        0,  32'hC,        32'h8,        1, 0);
        addV("flush",       0, 1, 0, 32'h0,        0,  32'h10,       32'h0,        0, 0);
        addV("postflush",   0, 0, 0, 32'h0,        0,  32'h14,       32'h10,       1, 0);
        addV("redirStall",  1, 0, 1, 32'h40,       0,  32'h40,       32'h0,        0, 0);
        addV("run40",       0, 0, 0, 32'h0,        0,  32'h44,       32'h40,       1, 0);
        addV("flushStall",  1, 1, 0, 32'h0,        0,  32'h44,       32'h0,        0, 0);
        addV("run44",       0, 0, 0, 32'h0,        0,  32'h48,       32'h44,       1, 0);
        addV("redir20",     0, 0, 1, 32'h20,       0,  32'h20,       32'h0,        0, 0);
        addV("halt",        0, 0, 0, 32'h0,        1,  32'h20,       32'h0,        0, 1);
        addV("halted1",     0, 0, 0, 32'h0,        0,  32'h20,       32'h0,        0, 1);
        addV("halted2",     1, 0, 0, 32'h0,        0,  32'h20,       32'h0,        0, 1);
        addV("unhalt",      0, 0, 1, 32'h0,        0,  32'h0,        32'h0,        0, 0);
        addV("resume",      0, 0, 0, 32'h0,        0,  32'h4,        32'h0,        1, 0);
        addV("redirEdge",   0, 0, 1, 32'h1FF8,     0,  32'h1FF8,     32'h0,        0, 0);
        addV("run1FF8",     0, 0, 0, 32'h0,        0,  32'h1FFC,     32'h1FF8,     1, 0);
        addV("run1FFC",     0, 0, 0, 32'h0,        0,  32'h2000,     32'h1FFC,     1, 0);
        addV("oorHalt",     0, 0, 0, 32'h0,        0,  32'h2000,     32'h0,        0, 1);
        addV("oorHeld",     0, 0, 0, 32'h0,        0,  32'h2000,     32'h0,        0, 1);
        addV("restart",     0, 0, 1, 32'h0,        0,  32'h0,        32'h0,        0, 0);
        addV("restart4",    0, 0, 0, 32'h0,        0,  32'h4,        32'h0,        1, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        addV("misRedir",    0, 0, 1, 32'h42,       0,  32'h4,        32'h0,        0, 1);
        addV("misAfter",    0, 0, 0, 32'h0,        0,  32'h4,        32'h0,        0, 1);
`else
        addV("misRedir",    0, 0, 1, 32'h42,       0,  32'h40,       32'h0,        0, 0);
        addV("misAfter",    0, 0, 0, 32'h0,        0,  32'h44,       32'h40,       1, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        checkReset("reset");
        rst_n = 1'b1;
        #1;
        checkOutput("bootHold", 32'h0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].stall, vecs[i].flush, vecs[i].redir, vecs[i].rpc, vecs[i].halt);
            checkOutput(vecs[i].name, vecs[i].eAddr, vecs[i].ePc, vecs[i].eValid, vecs[i].eHalted);
`ifdef FETCH_MISALIGN_CHECK_EN
            if (vecs[i].name == "misRedir") checkBit("misPulse", misMain, 1'b1);
            if (vecs[i].name == "misAfter") checkBit("misClear", misMain, 1'b0);
`endif
        end

        // Redirect to the last word: the wide instance wraps PC+4 to zero,
        // while the 2048-word instance sees an out-of-range PC and halts.
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0);
        checkWord("wideRedirAddr", addrWide, 32'hFFFF_FFFC);
        checkOutput("mainRedirTop", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkWord("wideWrapAddr", addrWide, 32'h0);
        checkWord("wideWrapPc", ifPcWide, 32'hFFFF_FFFC);
        checkWord("wideWrapPc4", ifPc4Wide, 32'h0);
        checkBit("wideWrapValid", validWide, 1'b1);
        checkOutput("mainTopOor", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1);

        // Bring the main instance back to a running, valid state, then reset mid-cycle
        applyStimulus(0, 0, 1, 32'h100, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("preReset", 32'h104, 32'h100, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkReset("asyncReset");
        @(posedge clk);
        #1;
        checkReset("resetHeld");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
